// File: rtl/fwd_operand_stage.sv
// Operand forwarding and load-use interlock at the ID/EX boundary.
// Optional performance counters are enabled by defining FWD_PERF_EN.
module fwd_operand_stage #(
    parameter int XLEN       = 64,
    parameter int NSTAGES    = 3,
    parameter int LOAD_STAGE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic            id_flush,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_we,
    input  logic            id_is_load,
    input  logic [1:0]      id_asel,
    input  logic [1:0]      id_bsel,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] rf_rs1,
    input  logic [XLEN-1:0] rf_rs2,
    input  logic [XLEN-1:0] ex_res,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_rs2
`ifdef FWD_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_fwd_cnt
`endif
);

    logic            vld_q  [NSTAGES];
    logic [4:0]      rd_q   [NSTAGES];
    logic            we_q   [NSTAGES];
    logic            ld_q   [NSTAGES];
    logic [XLEN-1:0] data_q [NSTAGES];
    logic            rdy    [NSTAGES];
    logic [XLEN-1:0] fdata  [NSTAGES];

    logic            hit1, hit2, rdy1, rdy2;
    logic [XLEN-1:0] fwd1, fwd2;
    logic            stall, fire;

    function automatic logic [XLEN-1:0] sel_a(input logic [1:0] s,
                                              input logic [XLEN-1:0] rs,
                                              input logic [XLEN-1:0] pc);
        case (s)
            2'd0:    return '0;
            2'd1:    return rs;
            default: return pc;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] sel_b(input logic [1:0] s,
                                              input logic [XLEN-1:0] rs,
                                              input logic [XLEN-1:0] imm);
        case (s)
            2'd0:    return '0;
            2'd1:    return rs;
            default: return imm;
        endcase
    endfunction

    // Per-entry readiness and the value it would forward right now.
    always_comb begin
        for (int k = 0; k < NSTAGES; k++) begin
            rdy[k] = !ld_q[k] || (k >= LOAD_STAGE);
            if (k == 0 && !ld_q[k])
                fdata[k] = ex_res;
            else if (k == LOAD_STAGE && ld_q[k])
                fdata[k] = mem_rdata;
            else
                fdata[k] = data_q[k];
        end
    end

    // Scan oldest to youngest so the lowest-index match overrides.
    always_comb begin
        hit1 = 1'b0;
        rdy1 = 1'b1;
        fwd1 = rf_rs1;
        hit2 = 1'b0;
        rdy2 = 1'b1;
        fwd2 = rf_rs2;
        for (int k = NSTAGES - 1; k >= 0; k--) begin
            if (vld_q[k] && we_q[k] && rd_q[k] == id_rs1 && id_rs1 != 5'd0 && id_use_rs1) begin
                hit1 = 1'b1;
                rdy1 = rdy[k];
                fwd1 = fdata[k];
            end
            if (vld_q[k] && we_q[k] && rd_q[k] == id_rs2 && id_rs2 != 5'd0 && id_use_rs2) begin
                hit2 = 1'b1;
                rdy2 = rdy[k];
                fwd2 = fdata[k];
            end
        end
    end

    assign stall    = id_valid && !id_flush && ((hit1 && !rdy1) || (hit2 && !rdy2));
    assign id_ready = !stall;
    assign fire     = id_valid && id_ready && !id_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NSTAGES; k++) begin
                vld_q[k] <= 1'b0;
                rd_q[k]  <= 5'd0;
                we_q[k]  <= 1'b0;
                ld_q[k]  <= 1'b0;
            end
        end else begin
            for (int k = NSTAGES - 1; k > 0; k--) begin
                vld_q[k] <= vld_q[k-1];
                rd_q[k]  <= rd_q[k-1];
                we_q[k]  <= we_q[k-1];
                ld_q[k]  <= ld_q[k-1];
            end
            vld_q[0] <= fire;
            rd_q[0]  <= id_rd;
            we_q[0]  <= id_we;
            ld_q[0]  <= id_is_load;
        end
    end

    // Result data travels with its entry; entry 0 never holds a stored value.
    always_ff @(posedge clk) begin
        for (int k = NSTAGES - 1; k > 0; k--)
            data_q[k] <= fdata[k-1];
        data_q[0] <= '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_rs2   <= '0;
        end else begin
            ex_valid <= fire;
            if (fire) begin
                ex_a   <= sel_a(id_asel, fwd1, id_pc);
                ex_b   <= sel_b(id_bsel, fwd2, id_imm);
                ex_rs2 <= fwd2;
            end
        end
    end

`ifdef FWD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_fwd_cnt   <= '0;
        end else begin
            if (stall && perf_stall_cnt != 32'hFFFF_FFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (fire && (hit1 || hit2) && perf_fwd_cnt != 32'hFFFF_FFFF)
                perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Directed bench for fwd_operand_stage with default parameters.
module tb_fwd_operand_stage;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid, id_ready, id_flush;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            id_use_rs1, id_use_rs2, id_we, id_is_load;
    logic [1:0]      id_asel, id_bsel;
    logic [XLEN-1:0] id_pc, id_imm, rf_rs1, rf_rs2, ex_res, mem_rdata;
    logic            ex_valid;
    logic [XLEN-1:0] ex_a, ex_b, ex_rs2;
`ifdef FWD_PERF_EN
    logic [31:0]     perf_stall_cnt, perf_fwd_cnt;
`endif

    int total = 0;
    int bad   = 0;

    fwd_operand_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready), .id_flush(id_flush),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
        .id_asel(id_asel), .id_bsel(id_bsel),
        .id_pc(id_pc), .id_imm(id_imm),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .ex_res(ex_res), .mem_rdata(mem_rdata),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_rs2(ex_rs2)
`ifdef FWD_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_valid = 0; id_flush = 0; id_rs1 = 0; id_rs2 = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_rd = 0; id_we = 0; id_is_load = 0;
        id_asel = 0; id_bsel = 0; id_pc = 0; id_imm = 0;
        rf_rs1 = 0; rf_rs2 = 0; ex_res = 0; mem_rdata = 0;
    endtask

    initial begin
        clr();
        rst = 1;
        repeat (2) step();
        check("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
        check("rst_ex_a", ex_a, 64'd0);
        check("rst_ex_b", ex_b, 64'd0);
        check("rst_ex_rs2", ex_rs2, 64'd0);
        check("rst_id_ready", {63'd0, id_ready}, 64'd1);
        rst = 0;

        // Back-to-back ALU forwarding from EX
        id_valid = 1; id_rd = 5; id_we = 1;
        step();
        clr();
        id_valid = 1; id_rs1 = 5; id_rs2 = 5; id_use_rs1 = 1; id_use_rs2 = 1;
        id_rd = 6; id_we = 1; id_asel = 1; id_bsel = 1;
        ex_res = 64'h11; rf_rs1 = 64'h99; rf_rs2 = 64'h99;
        #1 check("b2b_ready", {63'd0, id_ready}, 64'd1);
        step();
        check("b2b_valid", {63'd0, ex_valid}, 64'd1);
        check("b2b_a", ex_a, 64'h11);
        check("b2b_b", ex_b, 64'h11);

        // Load-use: one stall cycle, then mem_rdata forwarded
        clr();
        id_valid = 1; id_rd = 7; id_we = 1; id_is_load = 1;
        step();
        clr();
        id_valid = 1; id_rs1 = 7; id_use_rs1 = 1; id_asel = 1; id_rd = 8; id_we = 1;
        rf_rs1 = 64'h55;
        #1 check("lu_stall", {63'd0, id_ready}, 64'd0);
        step();
        check("lu_bubble", {63'd0, ex_valid}, 64'd0);
        mem_rdata = 64'hDEAD;
        #1 check("lu_release", {63'd0, id_ready}, 64'd1);
        step();
        check("lu_valid", {63'd0, ex_valid}, 64'd1);
        check("lu_a", ex_a, 64'hDEAD);

        // Youngest producer wins
        clr();
        id_valid = 1; id_rd = 3; id_we = 1;
        step();
        ex_res = 64'hA;
        step();
        clr();
        id_valid = 1; id_rs1 = 3; id_use_rs1 = 1; id_asel = 1; ex_res = 64'hB;
        #1 check("young_ready", {63'd0, id_ready}, 64'd1);
        step();
        check("young_a", ex_a, 64'hB);

        // Load at distance 2: no stall, then WB forwarding, then dropped
        clr();
        id_valid = 1; id_rd = 10; id_we = 1; id_is_load = 1;
        step();
        clr();
        step();
        id_valid = 1; id_rs1 = 10; id_use_rs1 = 1; id_asel = 1; mem_rdata = 64'hBEEF;
        #1 check("ld2_ready", {63'd0, id_ready}, 64'd1);
        step();
        check("ld2_a", ex_a, 64'hBEEF);
        clr();
        id_valid = 1; id_rs2 = 10; id_use_rs2 = 1; id_bsel = 1; rf_rs2 = 64'h22;
        step();
        check("wb_b", ex_b, 64'hBEEF);
        check("wb_rs2", ex_rs2, 64'hBEEF);
        step();
        check("retired_b", ex_b, 64'h22);

        // Store data forwarded from MEM, immediate on B
        clr();
        id_valid = 1; id_rd = 9; id_we = 1;
        step();
        clr();
        ex_res = 64'h1234;
        step();
        check("st_bubble", {63'd0, ex_valid}, 64'd0);
        clr();
        id_valid = 1; id_rs2 = 9; id_use_rs2 = 1; id_bsel = 2; id_imm = 64'd8;
        rf_rs2 = 64'h777; ex_res = 64'h5555;
        step();
        check("st_rs2", ex_rs2, 64'h1234);
        check("st_b", ex_b, 64'd8);
        check("st_a", ex_a, 64'd0);

        // x0 is never forwarded
        clr();
        id_valid = 1; id_rd = 0; id_we = 1;
        step();
        clr();
        id_valid = 1; id_rs1 = 0; id_use_rs1 = 1; id_asel = 1; ex_res = 64'hFF;
        #1 check("x0_ready", {63'd0, id_ready}, 64'd1);
        step();
        check("x0_a", ex_a, 64'd0);

        // Flush overrides a load-use stall
        clr();
        id_valid = 1; id_rd = 7; id_we = 1; id_is_load = 1;
        id_asel = 2; id_pc = 64'h40; id_bsel = 3; id_imm = 64'h4;
        step();
        check("pc_a", ex_a, 64'h40);
        check("imm_b", ex_b, 64'h4);
        clr();
        id_valid = 1; id_rs1 = 7; id_use_rs1 = 1; id_asel = 1;
        #1 check("fl_stall", {63'd0, id_ready}, 64'd0);
        id_flush = 1;
        #1 check("fl_ready", {63'd0, id_ready}, 64'd1);
        step();
        check("fl_bubble", {63'd0, ex_valid}, 64'd0);

        // Asynchronous reset during a stall
        clr();
        id_valid = 1; id_rd = 7; id_we = 1; id_is_load = 1;
        id_asel = 2; id_pc = 64'h40; id_bsel = 3; id_imm = 64'h4;
        step();
        clr();
        id_valid = 1; id_rs1 = 7; id_use_rs1 = 1; id_asel = 1;
        #1 check("ar_stall", {63'd0, id_ready}, 64'd0);
        rst = 1;
        #1;
        check("ar_ready", {63'd0, id_ready}, 64'd1);
        check("ar_valid", {63'd0, ex_valid}, 64'd0);
        check("ar_a", ex_a, 64'd0);
        check("ar_b", ex_b, 64'd0);
        check("ar_rs2", ex_rs2, 64'd0);
        clr();
        step();
        rst = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fwd_operand_stage.md
Name: fwd_operand_stage

Overview:
- Parametrised operand-forwarding and load-use interlock block at the ID/EX boundary of the in-order RISC-V pipeline.
- Tracks in-flight writers in an internal NSTAGES-deep shift register: entry[0] is in EX, entry[1] in MEM, and so on down to WB.
- Picks the youngest ready producer for rs1/rs2 and stalls ID when the youngest match is not ready yet.
- Registers the selected ALU A/B operands and store data into EX. Forwarding applies to every opcode, with no branch or store exemption.

Parameters:
- XLEN, 64, operand/data width.
- NSTAGES, 3, tracked stages after ID (EX..WB); legal range 2..6.
- LOAD_STAGE, 1, entry index whose load data arrives on mem_rdata; legal range 1..NSTAGES-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  ID holds an instruction.
- id_ready  out  1  issue accepted this cycle (combinational, = !stall).
- id_flush  in  1  kill the ID instruction (branch taken in EX).
- id_rs1, id_rs2  in  5  source register indices.
- id_use_rs1, id_use_rs2  in  1  source register is read.
- id_rd  in  5  destination register.
- id_we  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- id_asel  in  2  A select: 0 = zero, 1 = rs1, 2/3 = pc.
- id_bsel  in  2  B select: 0 = zero, 1 = rs2, 2/3 = imm.
- id_pc, id_imm  in  XLEN  pc and immediate.
- rf_rs1, rf_rs2  in  XLEN  register-file read data (no internal bypass).
- ex_res  in  XLEN  ALU result of entry[0], combinational.
- mem_rdata  in  XLEN  load data of entry[LOAD_STAGE], combinational.
- ex_valid  out  1  EX holds a real instruction.
- ex_a, ex_b  out  XLEN  registered ALU operands.
- ex_rs2  out  XLEN  registered forwarded rs2 (store data, branch compare).

Behaviour:
- Reset: all entries invalid; ex_valid = 0, ex_a = 0, ex_b = 0, ex_rs2 = 0, counters = 0. Reset asserted mid-stall clears the stall at once, because no entries remain.
- Entry fields: valid, rd, we, is_load, data.
- Entry k is ready when:
  - non-load: always, with data = ex_res for k = 0 and stored data for k >= 1;
  - load: k >= LOAD_STAGE, with data = mem_rdata for k = LOAD_STAGE and stored data for k > LOAD_STAGE.
- Match for a source register: entry valid, we = 1, rd == rs, rs != 0, and id_use set.
  - Youngest match (lowest k) wins.
  - No match: use rf_rs*.
  - x0 is never forwarded; it reads as rf value.
- Stall: id_valid & !id_flush & (youngest rs1 match not ready | youngest rs2 match not ready).
- id_ready = !stall.
- Fire: id_valid & id_ready & !id_flush.
- Every posedge the shift register advances:
  - entry[k+1] <= entry[k], with data captured (ex_res at k = 0 for non-loads, mem_rdata at k = LOAD_STAGE for loads);
  - entry[0] <= the ID instruction on fire, otherwise a bubble (valid = 0);
  - entry[NSTAGES-1] is dropped; that instruction is writing the register file this cycle.
- Outputs on fire: ex_a = sel(asel, fwd_rs1, pc); ex_b = sel(bsel, fwd_rs2, imm); ex_rs2 = fwd_rs2; ex_valid = 1.
- Outputs on no fire: ex_valid = 0 and ex_a/ex_b/ex_rs2 hold their values.
- Latency: one cycle from ID to EX. With defaults, load-use costs exactly 1 stall cycle. A load followed at distance d costs max(0, LOAD_STAGE+1-d) stalls.
- id_flush has priority over stall: no issue, bubble inserted, id_ready = 1.
- A rd = 0 writer occupies an entry but never matches.

Optional Feature:
- Macro FWD_PERF_EN.
- Defined: adds outputs perf_stall_cnt (32-bit, +1 per stall cycle) and perf_fwd_cnt (32-bit, +1 per fired instruction with at least one forwarded source). Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: these ports and counters are absent; the rest of the block is identical.

Test Plan:
- Back-to-back ALU: issue add x5 (ex_res = 0x11), then add x6, x5, x5 with asel = 1, bsel = 1 -> no stall; ex_a = ex_b = 0x11 next cycle.
- Load-use: lw x7 (mem_rdata = 0xDEAD next cycle), then sub using x7 -> id_ready = 0 for 1 cycle, ex_valid = 0 in the bubble, then ex_a = 0xDEAD.
- Youngest wins: x3 written with 0xA then 0xB in consecutive instructions, then a reader of x3 -> ex_a = 0xB.
- Store/branch: sw x9 with x9 in MEM holding 0x1234, bsel = 2, imm = 8 -> ex_rs2 = 0x1234, ex_b = 8.
- x0 guard: writer with rd = 0 and ex_res = 0xFF, then reader of x0 with rf_rs1 = 0 -> ex_a = 0, no stall.
- Flush plus reset: flush asserted during a load-use stall -> id_ready = 1, ex_valid = 0. Asserting rst mid-pipeline -> all outputs 0 immediately, with no clock edge needed.
